hex_coord_ctrl: RTL and testbench

Display controller that owns the six 7-segment outputs (to_hex_0..5) and shares them between two coordinate requesters, X and Y (mouse position). It arbitrates round-robin between the two value streams, clamps each accepted value to 999, and converts it to BCD on one shared sequential shift-add-3 converter. It then commits the decoded, leading-zero-blanked segment patterns to the X field (hex5..hex3) or the Y field (hex2..hex0). It sits between the coordinate-producing logic and the board HEX pins.

---
 rtl/hex_coord_if.sv | 22 ++
 rtl/hex_coord_ctrl.sv | 147 ++++++++++++++
 tb/tb_hex_coord_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hex_coord_if.sv
// Valid/ready request bundle carrying the X and Y coordinate streams into
// the HEX display controller.
interface hex_coord_if #(
    parameter int WIDTH = 10
);
    logic             x_valid;
    logic [WIDTH-1:0] x_data;
    logic             x_ready;
    logic             y_valid;
    logic [WIDTH-1:0] y_data;
    logic             y_ready;

    modport master (
        output x_valid, x_data, y_valid, y_data,
        input  x_ready, y_ready
    );

    modport slave (
        input  x_valid, x_data, y_valid, y_data,
        output x_ready, y_ready
    );
endinterface

// File: rtl/hex_coord_ctrl.sv
// Round-robin X/Y coordinate display: clamp to 999, sequential double-dabble,
// then commit blanked 7-segment digits to the X (hex5..3) or Y (hex2..0) field.
module hex_coord_ctrl #(
    parameter int WIDTH = 10
) (
    input  logic         clk_clk,
    input  logic         reset_reset,
    hex_coord_if.slave   bus,
    output logic         busy,
    output logic [6:0]   to_hex_0_readdata,
    output logic [6:0]   to_hex_1_readdata,
    output logic [6:0]   to_hex_2_readdata,
    output logic [6:0]   to_hex_3_readdata,
    output logic [6:0]   to_hex_4_readdata,
    output logic [6:0]   to_hex_5_readdata
);
    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;   // 0 = X, 1 = Y
    logic        target_q, target_d;           // 0 = X field, 1 = Y field
    logic [9:0]  bin_q, bin_d;
    logic [11:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [6:0]  hex_q [6];
    logic [6:0]  hex_d [6];

    logic             grant_x, grant_y;
    logic [WIDTH-1:0] sel_data;
    logic [9:0]       clamped;
    logic [11:0]      bcd_adj;
    logic [6:0]       seg_raw [3];
    logic [6:0]       seg_fin [3];

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        case (d)
            4'd0:    digit_seg = 7'h40;
            4'd1:    digit_seg = 7'h79;
            4'd2:    digit_seg = 7'h24;
            4'd3:    digit_seg = 7'h30;
            4'd4:    digit_seg = 7'h19;
            4'd5:    digit_seg = 7'h12;
            4'd6:    digit_seg = 7'h02;
            4'd7:    digit_seg = 7'h78;
            4'd8:    digit_seg = 7'h00;
            4'd9:    digit_seg = 7'h10;
            default: digit_seg = SEG_BLANK;
        endcase
    endfunction

    // Ties go to the side that did not win last time.
    assign grant_x = bus.x_valid & (~bus.y_valid | last_grant_q);
    assign grant_y = bus.y_valid & (~bus.x_valid | ~last_grant_q);

    assign bus.x_ready = (state_q == IDLE) & grant_x & ~reset_reset;
    assign bus.y_ready = (state_q == IDLE) & grant_y & ~reset_reset;

    assign sel_data = grant_x ? bus.x_data : bus.y_data;
    assign clamped  = (sel_data > WIDTH'(999)) ? 10'd999 : sel_data[9:0];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_digit
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                        bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
            assign seg_raw[gi] = digit_seg(bcd_q[gi*4 +: 4]);
        end
    endgenerate

    assign seg_fin[0] = seg_raw[0];
    assign seg_fin[1] = (bcd_q[11:4] == 8'd0) ? SEG_BLANK : seg_raw[1];
    assign seg_fin[2] = (bcd_q[11:8] == 4'd0) ? SEG_BLANK : seg_raw[2];

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        target_d     = target_q;
        bin_d        = bin_q;
        bcd_d        = bcd_q;
        cnt_d        = cnt_q;
        for (int i = 0; i < 6; i++) hex_d[i] = hex_q[i];

        case (state_q)
            IDLE: begin
                if (bus.x_ready || bus.y_ready) begin
                    bin_d        = clamped;
                    bcd_d        = 12'd0;
                    cnt_d        = 4'd0;
                    target_d     = grant_y;
                    last_grant_d = grant_y;
                    state_d      = CONV;
                end
            end
            CONV: begin
                bcd_d = {bcd_adj[10:0], bin_q[9]};
                bin_d = {bin_q[8:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd9) state_d = COMMIT;
            end
            COMMIT: begin
                for (int i = 0; i < 3; i++) begin
                    if (target_q) hex_d[i]     = seg_fin[i];
                    else          hex_d[i + 3] = seg_fin[i];
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            target_q     <= 1'b0;
            bin_q        <= 10'd0;
            bcd_q        <= 12'd0;
            cnt_q        <= 4'd0;
            busy_q       <= 1'b0;
            for (int i = 0; i < 6; i++)
                hex_q[i] <= (i == 0 || i == 3) ? SEG_ZERO : SEG_BLANK;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            target_q     <= target_d;
            bin_q        <= bin_d;
            bcd_q        <= bcd_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            for (int i = 0; i < 6; i++) hex_q[i] <= hex_d[i];
        end
    end

    assign busy              = busy_q;
    assign to_hex_0_readdata = hex_q[0];
    assign to_hex_1_readdata = hex_q[1];
    assign to_hex_2_readdata = hex_q[2];
    assign to_hex_3_readdata = hex_q[3];
    assign to_hex_4_readdata = hex_q[4];
    assign to_hex_5_readdata = hex_q[5];
endmodule

// File: tb/tb_hex_coord_ctrl.sv
// Randomized self-checking bench for hex_coord_ctrl against a decimal
// arithmetic model of the displayed digits.
module tb_hex_coord_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       busy;
    logic [6:0] hex [6];
    logic [6:0] exp_hex [6];
    int         total = 0;
    int         bad   = 0;

    hex_coord_if #(.WIDTH(10)) bus ();

    hex_coord_ctrl #(.WIDTH(10)) dut (
        .clk_clk           (clk),
        .reset_reset       (rst),
        .bus               (bus.slave),
        .busy              (busy),
        .to_hex_0_readdata (hex[0]),
        .to_hex_1_readdata (hex[1]),
        .to_hex_2_readdata (hex[2]),
        .to_hex_3_readdata (hex[3]),
        .to_hex_4_readdata (hex[4]),
        .to_hex_5_readdata (hex[5])
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_digit(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return tbl[d];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) exp_hex[i] = (i == 0 || i == 3) ? 7'h40 : 7'h7F;
    endtask

    // side 0 = X (hex5..3), 1 = Y (hex2..0)
    task automatic model_commit(input bit side, input int value);
        int v, h, t, u, base;
        v    = (value > 999) ? 999 : value;
        h    = v / 100;
        t    = (v / 10) % 10;
        u    = v % 10;
        base = side ? 0 : 3;
        exp_hex[base]     = ref_digit(u);
        exp_hex[base + 1] = (h == 0 && t == 0) ? 7'h7F : ref_digit(t);
        exp_hex[base + 2] = (h == 0) ? 7'h7F : ref_digit(h);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.x_valid = 1'b0;
        bus.y_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.x_valid = 1'b1;
        bus.y_valid = 1'b1;
        #1;
        total++;
        if (bus.x_ready !== 1'b0 || bus.y_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_blocks_ready: x_ready=%b y_ready=%b want 0 0", bus.x_ready, bus.y_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.x_valid = 1'b0;
        bus.y_valid = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (hex[i] !== exp_hex[i]) begin
                bad++;
                $display("FAIL reset_hex%0d: got %h want %h", i, hex[i], exp_hex[i]);
            end
        end
        total++;
        if (busy !== 1'b0 || bus.x_ready !== 1'b0 || bus.y_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: busy=%b x_ready=%b y_ready=%b want 0 0 0", busy, bus.x_ready, bus.y_ready);
        end
        $display("test_reset checked");
    endtask

    // One handshake on a single side, then check the busy window and the commit.
    task automatic do_xfer(input bit side, input int value);
        int  w;
        logic rdy, other;
        @(negedge clk);
        if (side) begin bus.y_valid = 1'b1; bus.y_data = 10'(value); end
        else      begin bus.x_valid = 1'b1; bus.x_data = 10'(value); end
        #1;
        w = 0;
        rdy = side ? bus.y_ready : bus.x_ready;
        while (!rdy && w < 30) begin
            @(negedge clk); #1;
            rdy = side ? bus.y_ready : bus.x_ready;
            w++;
        end
        other = side ? bus.x_ready : bus.y_ready;
        total++;
        if (rdy !== 1'b1 || other !== 1'b0 || w != 0) begin
            bad++;
            $display("FAIL xfer_ready side=%0d: ready=%b other=%b wait=%0d want 1 0 0", side, rdy, other, w);
        end
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin bus.x_valid = 1'b0; bus.y_valid = 1'b0; end
            #1;
            if (k == 12) model_commit(side, value);
            if (k == 11 || k == 12) begin
                for (int i = 0; i < 6; i++) begin
                    total++;
                    if (hex[i] !== exp_hex[i]) begin
                        bad++;
                        $display("FAIL xfer_hex%0d val=%0d t+%0d: got %h want %h", i, value, k, hex[i], exp_hex[i]);
                    end
                end
            end
            total++;
            if (busy !== (k < 12)) begin
                bad++;
                $display("FAIL xfer_busy t+%0d: got %b want %b", k, busy, k < 12);
            end
        end
        $display("xfer side=%0d value=%0d hex=%h %h %h %h %h %h", side, value,
                 hex[5], hex[4], hex[3], hex[2], hex[1], hex[0]);
    endtask

    task automatic test_single();
        bit sides [8];
        int vals  [8];
        sides = '{0, 1, 1, 0, 0, 1, 0, 1};
        vals  = '{123, 1023, 7, 999, 0, 10, 100, 998};
        for (int i = 0; i < 8; i++) do_xfer(sides[i], vals[i]);
        do_xfer(0, int'($urandom_range(0, 1023)));
        do_xfer(1, int'($urandom_range(0, 1023)));
    endtask

    task automatic test_tie();
        do_reset();
        @(negedge clk);
        bus.x_valid = 1'b1; bus.x_data = 10'd5;
        bus.y_valid = 1'b1; bus.y_data = 10'd40;
        #1;
        total++;
        if (bus.x_ready !== 1'b1 || bus.y_ready !== 1'b0) begin
            bad++;
            $display("FAIL tie_first: x_ready=%b y_ready=%b want 1 0", bus.x_ready, bus.y_ready);
        end
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) bus.x_valid = 1'b0;
            #1;
            total++;
            if (bus.y_ready !== (k == 12)) begin
                bad++;
                $display("FAIL tie_y_ready t+%0d: got %b want %b", k, bus.y_ready, k == 12);
            end
        end
        model_commit(0, 5);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) bus.y_valid = 1'b0;
        end
        #1;
        model_commit(1, 40);
        for (int i = 0; i < 6; i++) begin
            total++;
            if (hex[i] !== exp_hex[i]) begin
                bad++;
                $display("FAIL tie_hex%0d: got %h want %h", i, hex[i], exp_hex[i]);
            end
        end
        $display("tie x=5 y=40 hex=%h %h %h %h %h %h", hex[5], hex[4], hex[3], hex[2], hex[1], hex[0]);
    endtask

    task automatic test_stream();
        int  last_hs = -1, pend_cyc = -1, pend_val = 0, nhs = 0;
        bit  pend_side = 0, exp_side = 0, chg_x = 0, chg_y = 0, side;
        do_reset();
        @(negedge clk);
        bus.x_valid = 1'b1; bus.x_data = 10'($urandom_range(0, 1023));
        bus.y_valid = 1'b1; bus.y_data = 10'($urandom_range(0, 1023));
        for (int cyc = 0; cyc < 130; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (chg_x) bus.x_data = 10'($urandom_range(0, 1023));
            if (chg_y) bus.y_data = 10'($urandom_range(0, 1023));
            chg_x = 0; chg_y = 0;
            #1;
            total++;
            if (bus.x_ready && bus.y_ready) begin
                bad++;
                $display("FAIL stream_onehot cyc=%0d: both ready", cyc);
            end
            if (cyc == pend_cyc) begin
                model_commit(pend_side, pend_val);
                for (int i = 0; i < 6; i++) begin
                    total++;
                    if (hex[i] !== exp_hex[i]) begin
                        bad++;
                        $display("FAIL stream_hex%0d val=%0d: got %h want %h", i, pend_val, hex[i], exp_hex[i]);
                    end
                end
            end
            if (bus.x_ready || bus.y_ready) begin
                side = bus.y_ready;
                total++;
                if (side !== exp_side) begin
                    bad++;
                    $display("FAIL stream_order cyc=%0d: got side %0d want %0d", cyc, side, exp_side);
                end
                if (last_hs >= 0) begin
                    total++;
                    if (cyc - last_hs != 12) begin
                        bad++;
                        $display("FAIL stream_gap cyc=%0d: got %0d want 12", cyc, cyc - last_hs);
                    end
                end
                pend_side = side;
                pend_val  = side ? int'(bus.y_data) : int'(bus.x_data);
                pend_cyc  = cyc + 12;
                $display("handshake cyc=%0d side=%0d value=%0d", cyc, side, pend_val);
                exp_side  = ~side;
                last_hs   = cyc;
                nhs++;
                if (side) chg_y = 1; else chg_x = 1;
            end
        end
        total++;
        if (nhs < 10) begin
            bad++;
            $display("FAIL stream_count: got %0d handshakes want >= 10", nhs);
        end
        @(negedge clk);
        bus.x_valid = 1'b0;
        bus.y_valid = 1'b0;
    endtask

    task automatic test_reset_abort();
        do_reset();
        @(negedge clk);
        bus.x_valid = 1'b1; bus.x_data = 10'd777;
        #1;
        total++;
        if (bus.x_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_accept: x_ready=%b want 1", bus.x_ready);
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) bus.x_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_busy: got %b want 0", busy);
        end
        for (int c = 0; c < 20; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            for (int i = 0; i < 6; i++) begin
                total++;
                if (hex[i] !== exp_hex[i]) begin
                    bad++;
                    $display("FAIL abort_hex%0d c=%0d: got %h want %h", i, c, hex[i], exp_hex[i]);
                end
            end
        end
        $display("reset_abort value=777 hex=%h %h %h busy=%b", hex[5], hex[4], hex[3], busy);
    endtask

    initial begin
        bus.x_valid = 1'b0; bus.x_data = '0;
        bus.y_valid = 1'b0; bus.y_data = '0;
        model_reset();
        test_reset();
        test_single();
        test_tie();
        test_stream();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
